// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling engine.
package pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      FINAL,
      EMIT,
      DONE
   } pool_state_e;

   // Guard bits above DATA_W so a 4x4 sum of extreme samples never wraps.
   localparam int ACC_GUARD = 5;

   function automatic logic [1:0] log2_win(input logic [2:0] w);
      logic [1:0] l;
      case (w)
         3'd2:    l = 2'd1;
         3'd4:    l = 2'd2;
         default: l = 2'd0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/pool_reduce.sv
// Window reducer: running signed max or sum, result registered after each sample.
// clr marks the first sample of a window and reloads the accumulator from it.
module pool_reduce
   import pool_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] sample,
   input  pool_mode_e               mode,
   input  logic [2:0]               shift,
   output logic signed [DATA_W-1:0] result
);
   localparam int ACC_W = DATA_W + ACC_GUARD;

   logic signed [ACC_W-1:0]  acc_q, acc_d, smp_ext, shifted;
   logic signed [DATA_W-1:0] res_q, res_d;

   always_comb begin
      smp_ext = ACC_W'(sample);
      acc_d   = acc_q;
      if (en) begin
         if (clr)
            acc_d = smp_ext;
         else if (mode == POOL_AVG)
            acc_d = acc_q + smp_ext;
         else if (smp_ext > acc_q)
            acc_d = smp_ext;
      end
      shifted = acc_d >>> shift;
      res_d   = (mode == POOL_AVG) ? shifted[DATA_W-1:0] : acc_d[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         res_q <= '0;
      end else if (en) begin
         acc_q <= acc_d;
         res_q <= res_d;
      end
   end

   assign result = res_q;

endmodule

// File: rtl/pool_stream_engine.sv
// Streams a row-major feature map from RAM, pools each WxW window (stride S), emits on valid/ready.
// One result per W*W+2 cycles with out_ready high; a stalled result holds and no reads are issued.
module pool_stream_engine
   import pool_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int DIM_W   = 6,
   parameter int ADDR_W  = 12,
   parameter int MAX_WIN = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [DIM_W-1:0]         img_size,
   input  logic [2:0]               win_size,
   input  logic [2:0]               stride,
   input  logic                     mode,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic signed [DATA_W-1:0] rd_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);
   localparam int SW = DIM_W + 2;
   localparam int PW = 2 * DIM_W + 2;

   pool_state_e       state_q;
   pool_mode_e        mode_q;
   logic [DIM_W-1:0]  n_q, rb_q, cb_q, rb_d, cb_d;
   logic [2:0]        w_q, s_q, shift_q, r_q, c_q, r_d, c_d;
   logic              rd_en_q, rd_first_q, smp_vld_q, smp_first_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              out_valid_q, out_last_q, busy_q, done_q, cfg_err_q;
   logic              cfg_bad, col_more, row_more, row_end, win_end;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [DIM_W-1:0] rb, input logic [2:0] r,
                                                   input logic [DIM_W-1:0] cb, input logic [2:0] c,
                                                   input logic [DIM_W-1:0] n);
      logic [PW-1:0] a;
      a = (PW'(rb) + PW'(r)) * PW'(n) + PW'(cb) + PW'(c);
      return ADDR_W'(a);
   endfunction

   always_comb begin
      cfg_bad = (win_size == 3'd0) || (32'(win_size) > MAX_WIN) || (stride == 3'd0)
             || (SW'(win_size) > SW'(img_size))
             || (mode && !(win_size == 3'd1 || win_size == 3'd2 || win_size == 3'd4));

      // Only whole windows are emitted: step on while the next window still fits.
      col_more = (SW'(cb_q) + SW'(s_q) + SW'(w_q)) <= SW'(n_q);
      row_more = (SW'(rb_q) + SW'(s_q) + SW'(w_q)) <= SW'(n_q);
      rb_d     = col_more ? rb_q : rb_q + DIM_W'(s_q);
      cb_d     = col_more ? cb_q + DIM_W'(s_q) : '0;

      row_end  = (c_q == w_q - 3'd1);
      win_end  = row_end && (r_q == w_q - 3'd1);
      r_d      = row_end ? r_q + 3'd1 : r_q;
      c_d      = row_end ? 3'd0 : c_q + 3'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mode_q      <= POOL_MAX;
         n_q         <= '0;
         w_q         <= '0;
         s_q         <= '0;
         shift_q     <= '0;
         rb_q        <= '0;
         cb_q        <= '0;
         r_q         <= '0;
         c_q         <= '0;
         rd_en_q     <= 1'b0;
         rd_first_q  <= 1'b0;
         rd_addr_q   <= '0;
         smp_vld_q   <= 1'b0;
         smp_first_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         // RAM returns data one cycle after the strobe; align the sample tags with it.
         smp_vld_q   <= rd_en_q;
         smp_first_q <= rd_first_q;
         unique case (state_q)
            IDLE: if (start) begin
               n_q     <= img_size;
               w_q     <= win_size;
               s_q     <= stride;
               mode_q  <= pool_mode_e'(mode);
               shift_q <= {log2_win(win_size), 1'b0};
               if (cfg_bad) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  cfg_err_q <= 1'b1;
               end else begin
                  state_q    <= FETCH;
                  busy_q     <= 1'b1;
                  rb_q       <= '0;
                  cb_q       <= '0;
                  r_q        <= '0;
                  c_q        <= '0;
                  rd_en_q    <= 1'b1;
                  rd_first_q <= 1'b1;
                  rd_addr_q  <= '0;
               end
            end
            FETCH: begin
               rd_first_q <= 1'b0;
               if (win_end) begin
                  rd_en_q <= 1'b0;
                  state_q <= FINAL;
               end else begin
                  r_q       <= r_d;
                  c_q       <= c_d;
                  rd_addr_q <= word_addr(rb_q, r_d, cb_q, c_d, n_q);
               end
            end
            FINAL: begin
               state_q     <= EMIT;
               out_valid_q <= 1'b1;
               out_last_q  <= !col_more && !row_more;
            end
            EMIT: if (out_ready) begin
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
               if (out_last_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= FETCH;
                  rb_q       <= rb_d;
                  cb_q       <= cb_d;
                  r_q        <= '0;
                  c_q        <= '0;
                  rd_en_q    <= 1'b1;
                  rd_first_q <= 1'b1;
                  rd_addr_q  <= word_addr(rb_d, 3'd0, cb_d, 3'd0, n_q);
               end
            end
            DONE: begin
               done_q    <= 1'b0;
               cfg_err_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   pool_reduce #(.DATA_W(DATA_W)) u_reduce (
      .clk    (clk),
      .reset  (reset),
      .clr    (smp_first_q),
      .en     (smp_vld_q),
      .sample (rd_data),
      .mode   (mode_q),
      .shift  (shift_q),
      .result (out_data)
   );

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pool_stream_engine.sv
// Directed bench for pool_stream_engine: vector table plus back-pressure and mid-map reset sequences.
module tb_pool_stream_engine;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [5:0]          img_size = '0;
   logic [2:0]          win_size = '0;
   logic [2:0]          stride = '0;
   logic                mode = 1'b0;
   logic                rd_en;
   logic [11:0]         rd_addr;
   logic signed [15:0]  rd_data = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic signed [15:0]  out_data;
   logic                out_last, busy, done, cfg_err;

   always #5 clk = ~clk;

   pool_stream_engine #(.DATA_W(16), .DIM_W(6), .ADDR_W(12), .MAX_WIN(5)) dut (
      .clk(clk), .reset(reset), .start(start), .img_size(img_size), .win_size(win_size),
      .stride(stride), .mode(mode), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   logic signed [15:0] mem [64];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[5:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int out_q[$];
   bit last_q[$];
   int hs_q[$];
   int addr_q[$];
   int rd_cnt, done_cnt, cfgerr_cnt, done_cyc, first_rd, first_vld;
   bit busy_seen;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         out_q.push_back(int'(out_data));
         last_q.push_back(out_last);
         hs_q.push_back(cyc);
      end
      if (rd_en) begin
         if (rd_cnt == 0) first_rd = cyc;
         addr_q.push_back(int'(rd_addr));
         rd_cnt++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (cfg_err) cfgerr_cnt++;
      end
      if (busy) busy_seen = 1'b1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic clear_mon();
      out_q.delete(); last_q.delete(); hs_q.delete(); addr_q.delete();
      rd_cnt = 0; done_cnt = 0; cfgerr_cnt = 0; done_cyc = -1;
      first_rd = -1; first_vld = -1; busy_seen = 1'b0;
   endtask

   task automatic fill_mem(input int neg);
      for (int a = 0; a < 64; a++) mem[a] = neg ? 16'(-a) : 16'(a);
   endtask

   task automatic start_map(input int n, input int w, input int s, input int m);
      @(posedge clk); #1;
      img_size = 6'(n); win_size = 3'(w); stride = 3'(s); mode = m[0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk);
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct packed {
      int n; int w; int s; int mode; int neg; int err; int cnt;
   } vec_t;

   localparam int NV = 11;
   vec_t vec [NV];
   int   exp_tab [NV][9];

   task automatic run_vec(input int idx);
      vec_t v;
      bit   ok;
      int   act;
      v = vec[idx];
      fill_mem(v.neg);
      clear_mon();
      out_ready = 1'b1;
      start_map(v.n, v.w, v.s, v.mode);
      if (v.err != 0) begin
         @(negedge clk);
         chk("err_done", idx, int'(done), 1);
         chk("err_cfg_err", idx, int'(cfg_err), 1);
         chk("err_busy", idx, int'(busy), 0);
         repeat (3) @(posedge clk);
         chk("err_reads", idx, rd_cnt, 0);
         chk("err_busy_seen", idx, int'(busy_seen), 0);
         chk("err_done_cnt", idx, done_cnt, 1);
      end else begin
         wait_done(ok);
         chk("timeout", idx, int'(ok), 1);
         chk("count", idx, out_q.size(), v.cnt);
         for (int k = 0; k < v.cnt; k++) begin
            act = (k < out_q.size()) ? out_q[k] : 32'h7fffffff;
            chk("data", idx * 10 + k, act, exp_tab[idx][k]);
         end
         for (int k = 0; k < out_q.size(); k++)
            chk("last", idx * 10 + k, int'(last_q[k]), (k == v.cnt - 1) ? 1 : 0);
         chk("reads", idx, rd_cnt, v.cnt * v.w * v.w);
         chk("cfg_err_cnt", idx, cfgerr_cnt, 0);
         chk("latency", idx, first_vld - first_rd, v.w * v.w + 1);
         if (hs_q.size() > 0) chk("done_after_hs", idx, done_cyc - hs_q[$], 1);
         for (int k = 1; k < hs_q.size(); k++)
            chk("throughput", idx * 10 + k, hs_q[k] - hs_q[k-1], v.w * v.w + 2);
         for (int k = 0; k < v.w * v.w && k < addr_q.size(); k++)
            chk("addr_w0", idx * 10 + k, addr_q[k], (k / v.w) * v.n + (k % v.w));
      end
   endtask

   initial begin
      bit ok;

      //         n  w  s  mode neg err cnt
      vec[0]  = '{4, 2, 2, 0, 0, 0, 4};  exp_tab[0]  = '{5, 7, 13, 15, 0, 0, 0, 0, 0};
      vec[1]  = '{4, 2, 2, 1, 0, 0, 4};  exp_tab[1]  = '{2, 4, 10, 12, 0, 0, 0, 0, 0};
      vec[2]  = '{4, 2, 2, 1, 1, 0, 4};  exp_tab[2]  = '{-3, -5, -11, -13, 0, 0, 0, 0, 0};
      vec[3]  = '{4, 2, 1, 0, 0, 0, 9};  exp_tab[3]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
      vec[4]  = '{4, 4, 1, 1, 0, 0, 1};  exp_tab[4]  = '{7, 0, 0, 0, 0, 0, 0, 0, 0};
      vec[5]  = '{5, 3, 2, 0, 1, 0, 4};  exp_tab[5]  = '{0, -2, -10, -12, 0, 0, 0, 0, 0};
      vec[6]  = '{3, 1, 2, 0, 0, 0, 4};  exp_tab[6]  = '{0, 2, 6, 8, 0, 0, 0, 0, 0};
      vec[7]  = '{4, 3, 1, 1, 0, 1, 0};  exp_tab[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      vec[8]  = '{4, 0, 1, 0, 0, 1, 0};  exp_tab[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      vec[9]  = '{4, 5, 1, 0, 0, 1, 0};  exp_tab[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      vec[10] = '{4, 2, 0, 0, 0, 1, 0};  exp_tab[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

      clear_mon();
      fill_mem(0);
      #2 reset = 1'b0;
      #1;
      chk("rst_rd_en", 0, int'(rd_en), 0);
      chk("rst_rd_addr", 0, int'(rd_addr), 0);
      chk("rst_out_valid", 0, int'(out_valid), 0);
      chk("rst_out_data", 0, int'(out_data), 0);
      chk("rst_outs", 0, int'({out_last, busy, done, cfg_err}), 0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i);

      // Back-pressure on the first result, with a start pulse that must be ignored.
      fill_mem(0);
      clear_mon();
      out_ready = 1'b0;
      start_map(4, 2, 2, 0);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("bp_reach_valid", 0, int'(ok), 1);
      @(posedge clk); #1;
      img_size = 6'd4; win_size = 3'd3; stride = 3'd1; mode = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_data", k, int'(out_data), 5);
         chk("bp_rd_en", k, int'(rd_en), 0);
         chk("bp_valid", k, int'(out_valid), 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(ok);
      chk("bp_timeout", 0, int'(ok), 1);
      chk("bp_count", 0, out_q.size(), 4);
      for (int k = 0; k < 4; k++)
         chk("bp_data_seq", k, (k < out_q.size()) ? out_q[k] : 32'h7fffffff, exp_tab[0][k]);
      chk("bp_cfg_err", 0, cfgerr_cnt, 0);
      chk("bp_done_cnt", 0, done_cnt, 1);

      // Reset during the fetch of window 2, then a clean rerun.
      fill_mem(0);
      clear_mon();
      out_ready = 1'b1;
      start_map(4, 2, 2, 0);
      ok = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (out_q.size() == 2 && rd_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("mr_reach_fetch", 0, int'(ok), 1);
      #2 reset = 1'b0;
      #1;
      chk("mr_rd_en", 0, int'(rd_en), 0);
      chk("mr_rd_addr", 0, int'(rd_addr), 0);
      chk("mr_out_valid", 0, int'(out_valid), 0);
      chk("mr_out_data", 0, int'(out_data), 0);
      chk("mr_busy", 0, int'(busy), 0);
      chk("mr_outs", 0, int'({out_last, done, cfg_err}), 0);
      repeat (3) @(posedge clk);
      chk("mr_no_done", 0, done_cnt, 0);
      #3 reset = 1'b1;
      run_vec(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pool_stream_engine.md
Name: pool_stream_engine

Overview:
- Parametrised successor to the fixed 32x32 combinational-window pooling block.
- Reads a row-major feature map from an external synchronous RAM, one word per cycle, and reduces each window by MAX or power-of-two AVERAGE.
- Window size and stride are independent, and results stream out on a valid/ready interface.
- Sits between the conv-output feature buffer and the next layer's input buffer.

Parameters:
- DATA_W, 16, signed sample/result width.
- DIM_W, 6, width of image-size / coordinate fields (max image side 2^DIM_W-1).
- ADDR_W, 12, feature-RAM address width (must hold img_size^2-1).
- MAX_WIN, 5, largest supported window side.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; samples configuration inputs when idle.
- img_size  in  DIM_W  square image side N.
- win_size  in  3  window side W.
- stride  in  3  window step S.
- mode  in  1  0 = MAX, 1 = AVG.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM word address.
- rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  pooled result, signed.
- out_last  out  1  marks the final result of the map.
- busy  out  1  high from accepted start to done.
- done  out  1  1-cycle pulse at end of map or on config error.
- cfg_err  out  1  1-cycle pulse, coincident with done, on bad configuration.

Behaviour:
- Reset (reset=0, async): state IDLE; rd_en, rd_addr, out_valid, out_data, out_last, busy, done, cfg_err all 0; accumulators and counters cleared. Reset mid-map aborts immediately with no done pulse.
- start is ignored unless in IDLE. Configuration is latched on start and is constant for the whole map.
- Config check on start:
  - Illegal if W==0, W>MAX_WIN, S==0, W>N, or mode=AVG with W not in {1,2,4}.
  - Illegal config: next cycle done=1 and cfg_err=1, busy stays 0, no RAM reads.
- Output geometry: M = (N-W)/S + 1 per side (floor). Windows are visited row-major: (row_base, col_base) = (i*S, j*S) for i,j in 0..M-1. Partial edge windows are never emitted.
- FSM states: IDLE, FETCH, FINAL, EMIT, DONE.
  - IDLE -> FETCH on a legal start; busy=1.
  - FETCH: issues one read per cycle, W*W reads total, in window row-major order. rd_addr = (row_base+r)*N + col_base + c.
  - FETCH -> FINAL after the last read is issued.
  - FINAL: consumes the last rd_data and forms the result -> EMIT.
  - EMIT: out_valid=1. out_data and out_last are held stable until out_ready. No reads are issued while in EMIT.
    - On handshake with more windows remaining -> FETCH for the next window.
    - On handshake for the last window -> DONE.
  - DONE: done=1 for 1 cycle, busy=0 -> IDLE.
- Latency: out_valid rises W*W+1 cycles after entering FETCH for that window. With out_ready held high, throughput is one result per W*W+2 cycles.
- MAX mode: signed compare. The first sample loads the accumulator.
- AVG mode:
  - Sum is accumulated at width DATA_W+5.
  - Result = sum >>> (2*log2 W), an arithmetic shift (floor), truncated to DATA_W.
  - The result cannot overflow, so no saturation is applied.
- out_valid asserted together with out_ready in the same cycle counts as a handshake. out_ready while out_valid=0 is ignored.
- N==W gives exactly one output, which carries out_last=1.

Decomposition:
- pool_pkg:
  - pool_mode_e {POOL_MAX, POOL_AVG}.
  - pool_state_e {IDLE, FETCH, FINAL, EMIT, DONE}.
  - ACC_W = DATA_W+5.
  - Function log2_win(W) for W in {1,2,4}.
- Sub-module pool_reduce:
  - Inputs: clr, en, sample, mode, shift.
  - Output: registered max or shifted average.
  - Holds the accumulator and mode arithmetic; the top level owns the FSM, address generation and handshake.

Test Plan:
- Max, W=2, S=2: N=4, mem[a]=a, mode=MAX, out_ready=1 -> outputs 5,7,13,15; out_last only on 15; done 1 cycle after the last handshake; 16 reads total.
- Average: same map, mode=AVG -> outputs 2,4,10,12. With mem[a]=-a -> first output is -3 (floor of -10/4).
- Overlap: N=4, W=2, S=1, MAX -> 9 outputs 5,6,7,9,10,11,13,14,15; rd_addr sequence for window 0 is 0,1,4,5.
- Back-pressure: out_ready low for 10 cycles at the first result -> out_data stays 5, rd_en stays 0 throughout, the stream resumes correctly and the total output count is unchanged.
- Config errors: W=3 with mode=AVG, W=0, and W>N -> each gives done=1 and cfg_err=1 on the cycle after start, with no rd_en and busy=0. A start pulse while busy is ignored.
- Reset mid-map: assert reset=0 during FETCH of window 2 -> all outputs 0 immediately, no done. A new start after release produces the full correct sequence.
